mem_copy_engine: RTL

- Initiator-side master for the memory request/data interface: issues read requests, accepts read beats, issues write requests, supplies write beats.
- Copies `len` words from a source byte address to a destination byte address.
- Splits each copy into bursts of at most MAX_BURST_LEN words and stages each burst in an internal buffer.
- Sits between a control client (core/MMIO) and the memory model or memory controller.

---
 rtl/mem_copy_engine.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words from src to dst in bursts of up to
// MAX_BURST_LEN beats. Each burst is read into a local buffer and then written out.
// Only one request (read or write) is outstanding at any time.
module mem_copy_engine #(
  parameter int AXI_AWIDTH    = 32,
  parameter int AXI_DWIDTH    = 32,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AXI_AWIDTH-1:0] src_addr,
  input  logic [AXI_AWIDTH-1:0] dst_addr,
  input  logic [31:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  read_request_valid,
  input  logic                  read_request_ready,
  output logic [AXI_AWIDTH-1:0] read_request_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  input  logic [AXI_DWIDTH-1:0] read_data,
  input  logic                  read_data_valid,
  output logic                  read_data_ready,
  output logic                  write_request_valid,
  input  logic                  write_request_ready,
  output logic [AXI_AWIDTH-1:0] write_request_addr,
  output logic [31:0]           write_len,
  output logic [2:0]            write_size,
  output logic [AXI_DWIDTH-1:0] write_data,
  output logic                  write_data_valid,
  input  logic                  write_data_ready
);
  localparam int         BW   = $clog2(MAX_BURST_LEN);
  localparam logic [2:0] SIZE = 3'($clog2(AXI_DWIDTH/8));

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE} state_t;
  state_t state, state_nxt;

  logic [AXI_AWIDTH-1:0] cur_src, cur_dst;
  logic [31:0]           remaining, chunk, chunk_m1;
  logic [BW-1:0]         beat;      // beats accepted in RD_DATA / sent in WR_DATA
  logic [BW:0]           rd_ptr;    // next buffer word to prefetch in WR_DATA
  logic [AXI_DWIDTH-1:0] buffer [MAX_BURST_LEN];
  logic [AXI_DWIDTH-1:0] ram_q;     // prefetch register; drives write_data directly
  logic                  rq_vld;    // ram_q holds a beat not yet accepted
  logic                  rd_fire, wr_fire, ram_rd_en, last_rd, last_wr;

  assign chunk    = (remaining > 32'(MAX_BURST_LEN)) ? 32'(MAX_BURST_LEN) : remaining;
  assign chunk_m1 = chunk - 32'd1;

  // Outputs are forced low while reset is asserted.
  // This stops reset from consuming or driving beats during the reset cycle.
  assign busy                = (state != IDLE) && !rst;
  assign done                = (state == DONE) && !rst;
  assign read_request_valid  = (state == RD_REQ) && !rst;
  assign read_request_addr   = cur_src;
  assign read_len            = chunk_m1;
  assign read_size           = SIZE;
  assign read_data_ready     = (state == RD_DATA) && !rst;
  assign write_request_valid = (state == WR_REQ) && !rst;
  assign write_request_addr  = cur_dst;
  assign write_len           = chunk_m1;
  assign write_size          = SIZE;
  assign write_data          = ram_q;
  assign write_data_valid    = (state == WR_DATA) && rq_vld && !rst;

  assign rd_fire = read_data_ready && read_data_valid;
  assign wr_fire = write_data_valid && write_data_ready;
  assign last_rd = 32'(beat) == chunk_m1;
  assign last_wr = 32'(beat) == chunk_m1;
  // Refill the prefetch register when it is empty or is being drained this cycle.
  assign ram_rd_en = (state == WR_DATA) && (32'(rd_ptr) != chunk) && (!rq_vld || wr_fire);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == 32'd0) ? DONE : RD_REQ;
      RD_REQ:  if (read_request_valid && read_request_ready) state_nxt = RD_DATA;
      RD_DATA: if (rd_fire && last_rd) state_nxt = WR_REQ;
      WR_REQ:  if (write_request_valid && write_request_ready) state_nxt = WR_DATA;
      WR_DATA: if (wr_fire && last_wr) state_nxt = (remaining == chunk) ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, address/length tracking, beat counters, and prefetch control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      beat      <= '0;
      rd_ptr    <= '0;
      rq_vld    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          cur_src   <= src_addr;
          cur_dst   <= dst_addr;
          remaining <= len;
        end
        RD_DATA: if (rd_fire) beat <= last_rd ? '0 : beat + BW'(1);
        WR_DATA: begin
          if (ram_rd_en) rd_ptr <= rd_ptr + (BW+1)'(1);
          if (ram_rd_en)    rq_vld <= 1'b1;
          else if (wr_fire) rq_vld <= 1'b0;
          if (wr_fire) begin
            if (last_wr) begin
              beat      <= '0;
              rd_ptr    <= '0;
              rq_vld    <= 1'b0;
              cur_src   <= cur_src + AXI_AWIDTH'(chunk << SIZE);
              cur_dst   <= cur_dst + AXI_AWIDTH'(chunk << SIZE);
              remaining <= remaining - chunk;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Burst buffer: synchronous RAM, written by read beats and read into the prefetch register.
  always_ff @(posedge clk) begin
    if (rd_fire)   buffer[beat] <= read_data;
    if (ram_rd_en) ram_q <= buffer[rd_ptr[BW-1:0]];
  end
endmodule
